tx_packet_arbiter: RTL

Shares the single write port of the TX interface buffer between two requesters: the transaction-layer TLP source and the DLLP generator. Grants are packet-atomic: a multi-beat TLP is never interleaved with a DLLP. DLLPs have priority, and a starvation counter guarantees TLP progress. The block sits directly in front of the buffer write side and honours the buffer's full flag.

---
 rtl/tx_pkg.sv | 17 +
 rtl/tx_packet_arbiter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/tx_pkg.sv
// Shared definitions for the TX interface-buffer write arbiter.
// Holds the arbiter state encoding, packet-type codes and fixed DLLP framing values.
package tx_pkg;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        TLP_BUSY = 1'b1
    } arb_state_e;

    localparam logic TYPE_TLP  = 1'b0;
    localparam logic TYPE_DLLP = 1'b1;

    localparam int unsigned DLLP_WIDTH     = 64;
    localparam int unsigned DLLP_LEN_DW    = 2;
    localparam int unsigned DLLP_LAST_BYTE = 7;

endpackage

// File: rtl/tx_packet_arbiter.sv
// Packet-atomic arbiter sharing the TX buffer write port between the TLP source
// and the DLLP generator. DLLPs win in IDLE unless a waiting TLP SOP has been
// passed over STARVE_LIMIT times; a multi-beat TLP locks the grant until its end.
// Ports:
//   CLK, RST_L (async active-low), Soft_RST_blocks (sync clear), i_Full
//   i_TLP_*  : TLP beat request, o_TLP_Ready acceptance
//   i_DLLP_* : single-beat DLLP request, o_DLLP_Ready acceptance
//   o_WR_EN, o_SOP, o_End_Valid, o_Type, o_Length, o_Last_Byte, o_Data : buffer write
//   o_Err    : registered one-cycle protocol-error pulse
module tx_packet_arbiter
    import tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = 256,
    parameter int unsigned PACKET_LENGTH    = 11,
    parameter int unsigned SYMBOL_PTR_WIDTH = 5,
    parameter int unsigned STARVE_LIMIT     = 4,
    parameter int unsigned STARVE_CNT_WIDTH = 3
) (
    input  logic                        CLK,
    input  logic                        RST_L,
    input  logic                        Soft_RST_blocks,
    input  logic                        i_Full,
    input  logic                        i_TLP_Valid,
    input  logic                        i_TLP_SOP,
    input  logic                        i_TLP_End_Valid,
    input  logic [PACKET_LENGTH-1:0]    i_TLP_Length,
    input  logic [SYMBOL_PTR_WIDTH-1:0] i_TLP_Last_Byte,
    input  logic [0:DATA_WIDTH-1]       i_TLP_Data,
    output logic                        o_TLP_Ready,
    input  logic                        i_DLLP_Valid,
    input  logic [0:DLLP_WIDTH-1]       i_DLLP_Data,
    output logic                        o_DLLP_Ready,
    output logic                        o_WR_EN,
    output logic                        o_SOP,
    output logic                        o_End_Valid,
    output logic                        o_Type,
    output logic [PACKET_LENGTH-1:0]    o_Length,
    output logic [SYMBOL_PTR_WIDTH-1:0] o_Last_Byte,
    output logic [0:DATA_WIDTH-1]       o_Data,
    output logic                        o_Err
);

    localparam logic [STARVE_CNT_WIDTH-1:0] STARVE_MAX = STARVE_CNT_WIDTH'(STARVE_LIMIT);

    arb_state_e                  state, state_nxt;
    logic [STARVE_CNT_WIDTH-1:0] starve_cnt, starve_cnt_nxt;
    logic                        err_nxt;
    logic                        wr_ok;
    logic                        grant_dllp, grant_tlp;
    logic                        drop, tlp_wr, dllp_wr;
    logic                        tlp_sop_wait;

    // State, starvation counter and error pulse registers.
    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            state      <= IDLE;
            starve_cnt <= '0;
            o_Err      <= 1'b0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;
            o_Err      <= err_nxt;
        end
    end

    // Grant decision, zero-latency write mux, next-state and counter update.
    always_comb begin
        state_nxt      = state;
        starve_cnt_nxt = starve_cnt;
        err_nxt        = 1'b0;
        grant_dllp     = 1'b0;
        grant_tlp      = 1'b0;
        o_WR_EN        = 1'b0;
        o_SOP          = 1'b0;
        o_End_Valid    = 1'b0;
        o_Type         = TYPE_TLP;
        o_Length       = '0;
        o_Last_Byte    = '0;
        o_Data         = '0;
        o_TLP_Ready    = 1'b0;
        o_DLLP_Ready   = 1'b0;

        // Holding RST_L low also silences the write port immediately.
        wr_ok        = RST_L & ~i_Full & ~Soft_RST_blocks;
        tlp_sop_wait = i_TLP_Valid & i_TLP_SOP;

        if (state == IDLE) begin
            if (i_DLLP_Valid && !(tlp_sop_wait && starve_cnt == STARVE_MAX)) begin
                grant_dllp = 1'b1;
            end else begin
                grant_tlp = i_TLP_Valid;
            end
        end else begin
            grant_tlp = i_TLP_Valid;
        end

        // A continuation beat with no packet open is consumed but never written.
        drop    = grant_tlp & (state == IDLE) & ~i_TLP_SOP;
        tlp_wr  = grant_tlp & wr_ok & ~drop;
        dllp_wr = grant_dllp & wr_ok;

        o_TLP_Ready  = grant_tlp & wr_ok;
        o_DLLP_Ready = dllp_wr;
        o_WR_EN      = tlp_wr | dllp_wr;

        if (dllp_wr) begin
            o_SOP       = 1'b1;
            o_End_Valid = 1'b1;
            o_Type      = TYPE_DLLP;
            o_Length    = PACKET_LENGTH'(DLLP_LEN_DW);
            o_Last_Byte = SYMBOL_PTR_WIDTH'(DLLP_LAST_BYTE);
            o_Data      = {i_DLLP_Data, (DATA_WIDTH - DLLP_WIDTH)'(0)};
        end else if (tlp_wr) begin
            o_SOP       = i_TLP_SOP;
            o_End_Valid = i_TLP_End_Valid;
            o_Type      = TYPE_TLP;
            o_Length    = i_TLP_Length;
            o_Last_Byte = i_TLP_Last_Byte;
            o_Data      = i_TLP_Data;
        end

        case (state)
            IDLE:     if (tlp_wr && !i_TLP_End_Valid) state_nxt = TLP_BUSY;
            TLP_BUSY: if (tlp_wr && i_TLP_End_Valid)  state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase

        err_nxt = (drop & wr_ok) | ((state == TLP_BUSY) & tlp_wr & i_TLP_SOP);

        if (tlp_wr && i_TLP_SOP) begin
            starve_cnt_nxt = '0;
        end else if (dllp_wr && tlp_sop_wait && starve_cnt != STARVE_MAX) begin
            starve_cnt_nxt = starve_cnt + STARVE_CNT_WIDTH'(1);
        end

        if (Soft_RST_blocks) begin
            state_nxt      = IDLE;
            starve_cnt_nxt = '0;
            err_nxt        = 1'b0;
        end
    end

endmodule
